// File: rtl/lsu_dmem.sv
// Load/store unit in front of a byte-masked, word-addressed, single-port data memory.
// One request at a time; accesses that straddle a word boundary become two word accesses.
module lsu_dmem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W+1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_split,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_mask,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  input  logic [31:0]       i_mem_data
);

  typedef enum logic [2:0] {
    IDLE,
    A0,
    D0,
    D1,
    RESP
  } state_t;

  state_t state_reg;

  // Request context captured at acceptance; only what the later states still need.
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              unsigned_reg;
  logic [1:0]        off_reg;
  logic              split_reg;
  logic [ADDR_W-1:0] w1_reg;
  logic [3:0]        mask1_reg;
  logic [31:0]       data1_reg;
  logic [31:0]       lo_reg;

  function automatic logic [7:0] byte_mask8(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] smask;
    case (size)
      2'd0:    smask = 8'h01;
      2'd1:    smask = 8'h03;
      default: smask = 8'h0F;
    endcase
    return smask << off;
  endfunction

  function automatic logic [63:0] align64(input logic [31:0] wdata, input logic [1:0] off);
    return {32'b0, wdata} << {off, 3'b000};
  endfunction

  function automatic logic is_split(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'd1 && off == 2'd3) || (size[1] && off != 2'd0);
  endfunction

  // hi is passed as zero for unsplit accesses, so the same shift serves both cases.
  function automatic logic [31:0] extract(input logic [31:0] hi, input logic [31:0] lo,
                                          input logic [1:0] off, input logic [1:0] size,
                                          input logic uns);
    logic [31:0] r;
    r = 32'({hi, lo} >> {off, 3'b000});
    case (size)
      2'd0:    return uns ? {24'b0, r[7:0]}  : {{24{r[7]}}, r[7:0]};
      2'd1:    return uns ? {16'b0, r[15:0]} : {{16{r[15]}}, r[15:0]};
      default: return r;
    endcase
  endfunction

  logic [1:0]        req_off;
  logic [ADDR_W-1:0] req_w0;
  logic [7:0]        req_m8;
  logic [63:0]       req_s64;

  assign req_off = i_req_addr[1:0];
  assign req_w0  = i_req_addr[ADDR_W+1:2];
  assign req_m8  = byte_mask8(i_req_size, req_off);
  assign req_s64 = align64(i_req_wdata, req_off);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      o_req_ready  <= 1'b1;
      o_rsp_valid  <= 1'b0;
      o_rsp_rdata  <= 32'b0;
      o_rsp_split  <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_mask   <= 4'b0;
      o_mem_addr   <= '0;
      o_mem_data   <= 32'b0;
      we_reg       <= 1'b0;
      size_reg     <= 2'b0;
      unsigned_reg <= 1'b0;
      off_reg      <= 2'b0;
      split_reg    <= 1'b0;
      w1_reg       <= '0;
      mask1_reg    <= 4'b0;
      data1_reg    <= 32'b0;
      lo_reg       <= 32'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_req_valid) begin
            we_reg       <= i_req_we;
            size_reg     <= i_req_size;
            unsigned_reg <= i_req_unsigned;
            off_reg      <= req_off;
            split_reg    <= is_split(i_req_size, req_off);
            w1_reg       <= req_w0 + ADDR_W'(1);
            mask1_reg    <= req_m8[7:4];
            data1_reg    <= i_req_we ? req_s64[63:32] : 32'b0;
            o_req_ready  <= 1'b0;
            o_mem_addr   <= req_w0;
            o_mem_mask   <= req_m8[3:0];
            o_mem_we     <= i_req_we;
            o_mem_data   <= i_req_we ? req_s64[31:0] : 32'b0;
            state_reg    <= A0;
          end
        end
        A0: begin
          // The outputs registered here are what the memory sees during D0.
          if (split_reg) begin
            o_mem_addr <= w1_reg;
            o_mem_mask <= mask1_reg;
            o_mem_we   <= we_reg;
            o_mem_data <= data1_reg;
          end else begin
            o_mem_addr <= '0;
            o_mem_mask <= 4'b0;
            o_mem_we   <= 1'b0;
            o_mem_data <= 32'b0;
          end
          state_reg <= D0;
        end
        D0: begin
          if (!we_reg) begin
            lo_reg <= i_mem_data;
          end
          o_mem_addr <= '0;
          o_mem_mask <= 4'b0;
          o_mem_we   <= 1'b0;
          o_mem_data <= 32'b0;
          if (split_reg) begin
            state_reg <= D1;
          end else begin
            o_rsp_valid <= 1'b1;
            o_rsp_split <= 1'b0;
            o_rsp_rdata <= we_reg ? 32'b0
                                  : extract(32'b0, i_mem_data, off_reg, size_reg, unsigned_reg);
            state_reg   <= RESP;
          end
        end
        D1: begin
          o_rsp_valid <= 1'b1;
          o_rsp_split <= 1'b1;
          o_rsp_rdata <= we_reg ? 32'b0
                                : extract(i_mem_data, lo_reg, off_reg, size_reg, unsigned_reg);
          state_reg   <= RESP;
        end
        RESP: begin
          o_rsp_valid <= 1'b0;
          o_rsp_rdata <= 32'b0;
          o_rsp_split <= 1'b0;
          o_req_ready <= 1'b1;
          state_reg   <= IDLE;
        end
        default: begin
          o_req_ready <= 1'b1;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: directed vector table, reset-in-flight sequence, and random
// traffic checked against a byte-array model of memory.
module tb_lsu_dmem;

  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_split;
  logic        mem_we;
  logic [3:0]  mem_mask;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_dmem #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_we      (req_we),
    .i_req_size    (req_size),
    .i_req_unsigned(req_unsigned),
    .i_req_addr    (req_addr),
    .i_req_wdata   (req_wdata),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_rdata   (rsp_rdata),
    .o_rsp_split   (rsp_split),
    .o_mem_we      (mem_we),
    .o_mem_mask    (mem_mask),
    .o_mem_addr    (mem_addr),
    .o_mem_data    (mem_wdata),
    .i_mem_data    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: registers address/controls on the edge, read data next cycle.
  logic [31:0] mem_arr [0:255];
  bit          mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'b0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= mem_arr[mem_addr];
  end

  // Reference: flat byte-addressed memory, addresses wrap at 1024 bytes.
  logic [7:0] ref_mem [0:1023];

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  task automatic ref_store(input logic [9:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    for (int i = 0; i < nbytes(size); i++) ref_mem[(int'(addr) + i) % 1024] = wdata[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [9:0] addr, input logic [1:0] size, input logic uns);
    logic [31:0] v;
    int n;
    v = 32'b0;
    n = nbytes(size);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(addr) + i) % 1024];
    if (!uns && n == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
    if (!uns && n == 2 && v[15]) v[31:16] = 16'hFFFF;
    return v;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Results of the most recent transaction.
  int          got_lat;
  logic        got_rsp, got_after, got_split;
  logic [31:0] got_rdata;
  logic        a0_we, d0_we;
  logic [3:0]  a0_mask, d0_mask;
  logic [7:0]  a0_addr, d0_addr;
  logic [31:0] a0_data, d0_data;

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wdata);
    int wait_cyc;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    got_rsp = 1'b0;
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: ready=%0d required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    got_lat = 1;
    a0_we = mem_we; a0_mask = mem_mask; a0_addr = mem_addr; a0_data = mem_wdata;
    @(negedge clk);
    got_lat = 2;
    d0_we = mem_we; d0_mask = mem_mask; d0_addr = mem_addr; d0_data = mem_wdata;
    while (!rsp_valid && got_lat < 20) begin
      @(negedge clk);
      got_lat++;
    end
    got_rsp = rsp_valid; got_rdata = rsp_rdata; got_split = rsp_split;
    @(negedge clk);
    got_after = rsp_valid;
    $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h rdata=%h split=%0d lat=%0d",
             we, size, uns, addr, wdata, got_rdata, got_split, got_lat);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_split;
    int          exp_lat;
    logic [7:0]  a0_addr;
    logic [3:0]  a0_mask;
    logic [31:0] a0_data;
    logic [7:0]  d0_addr;
    logic [3:0]  d0_mask;
    logic [31:0] d0_data;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_we, r_uns, e_split;
    logic [1:0]  r_size, off;
    logic [9:0]  r_addr;
    logic [31:0] r_wdata, e_rdata, e_a0_data, e_d0_data;
    logic [3:0]  e_a0_mask, e_d0_mask;
    int          n;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0,        1'b0, 3, 8'h04, 4'hF, 32'hDEADBEEF, 8'h00, 4'h0, 32'h0};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 8'h04, 4'hF, 32'h0,        8'h00, 4'h0, 32'h0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 10'h013, 32'h00000080, 32'h0,        1'b0, 3, 8'h04, 4'h8, 32'h80000000, 8'h00, 4'h0, 32'h0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 10'h013, 32'h0,        32'hFFFFFF80, 1'b0, 3, 8'h04, 4'h8, 32'h0,        8'h00, 4'h0, 32'h0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 10'h013, 32'h0,        32'h00000080, 1'b0, 3, 8'h04, 4'h8, 32'h0,        8'h00, 4'h0, 32'h0};
    vecs[5]  = '{1'b1, 2'd2, 1'b0, 10'h010, 32'h87654321, 32'h0,        1'b0, 3, 8'h04, 4'hF, 32'h87654321, 8'h00, 4'h0, 32'h0};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 10'h012, 32'h0,        32'hFFFF8765, 1'b0, 3, 8'h04, 4'hC, 32'h0,        8'h00, 4'h0, 32'h0};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 10'h012, 32'h0,        32'h00008765, 1'b0, 3, 8'h04, 4'hC, 32'h0,        8'h00, 4'h0, 32'h0};
    vecs[8]  = '{1'b0, 2'd0, 1'b1, 10'h011, 32'h0,        32'h00000043, 1'b0, 3, 8'h04, 4'h2, 32'h0,        8'h00, 4'h0, 32'h0};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 10'h015, 32'h11223344, 32'h0,        1'b1, 4, 8'h05, 4'hE, 32'h22334400, 8'h06, 4'h1, 32'h00000011};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 10'h015, 32'h0,        32'h11223344, 1'b1, 4, 8'h05, 4'hE, 32'h0,        8'h06, 4'h1, 32'h0};
    vecs[11] = '{1'b1, 2'd1, 1'b0, 10'h3FF, 32'h0000ABCD, 32'h0,        1'b1, 4, 8'hFF, 4'h8, 32'hCD000000, 8'h00, 4'h1, 32'h000000AB};
    vecs[12] = '{1'b0, 2'd1, 1'b1, 10'h3FF, 32'h0,        32'h0000ABCD, 1'b1, 4, 8'hFF, 4'h8, 32'h0,        8'h00, 4'h1, 32'h0};
    vecs[13] = '{1'b0, 2'd3, 1'b0, 10'h010, 32'h0,        32'h87654321, 1'b0, 3, 8'h04, 4'hF, 32'h0,        8'h00, 4'h0, 32'h0};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 10'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",     32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata,      32'd0);
    check("rst_rsp_split", 32'(rsp_split), 32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_mask",  32'(mem_mask),  32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_data",  mem_wdata,      32'd0);
    rst = 1'b0; mem_clr = 1'b0;

    // Directed vectors
    foreach (vecs[i]) begin
      run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].we) ref_store(vecs[i].addr, vecs[i].size, vecs[i].wdata);
      check($sformatf("v%0d_rsp_seen", i),  32'(got_rsp),   32'd1);
      check($sformatf("v%0d_rdata", i),     got_rdata,      vecs[i].exp_rdata);
      check($sformatf("v%0d_split", i),     32'(got_split), 32'(vecs[i].exp_split));
      check($sformatf("v%0d_latency", i),   32'(got_lat),   32'(vecs[i].exp_lat));
      check($sformatf("v%0d_pulse", i),     32'(got_after), 32'd0);
      check($sformatf("v%0d_a0_addr", i),   32'(a0_addr),   32'(vecs[i].a0_addr));
      check($sformatf("v%0d_a0_mask", i),   32'(a0_mask),   32'(vecs[i].a0_mask));
      check($sformatf("v%0d_a0_we", i),     32'(a0_we),     32'(vecs[i].we));
      check($sformatf("v%0d_d0_we", i),     32'(d0_we),     32'(vecs[i].we & vecs[i].exp_split));
      if (vecs[i].we) check($sformatf("v%0d_a0_data", i), a0_data, vecs[i].a0_data);
      if (vecs[i].exp_split) begin
        check($sformatf("v%0d_d0_addr", i), 32'(d0_addr), 32'(vecs[i].d0_addr));
        check($sformatf("v%0d_d0_mask", i), 32'(d0_mask), 32'(vecs[i].d0_mask));
        if (vecs[i].we) check($sformatf("v%0d_d0_data", i), d0_data, vecs[i].d0_data);
      end
    end

    // Reset during D0 of a split store, with the request held valid throughout
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 10'h201; req_wdata = 32'hCAFEF00D;
    check("rr_idle_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("rr_a0_ready", 32'(req_ready), 32'd0);
    check("rr_a0_we",    32'(mem_we),    32'd1);
    @(negedge clk);
    check("rr_d0_ready", 32'(req_ready), 32'd0);
    check("rr_d0_we",    32'(mem_we),    32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rr_post_ready",     32'(req_ready), 32'd1);
    check("rr_post_mem_we",    32'(mem_we),    32'd0);
    check("rr_post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rr_post_mem_mask",  32'(mem_mask),  32'd0);
    check("rr_post_mem_addr",  32'(mem_addr),  32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rr_held_a0_ready", 32'(req_ready), 32'd0);
    check("rr_held_a0_addr",  32'(mem_addr),  32'h80);
    got_lat = 1;
    while (!rsp_valid && got_lat < 20) begin
      @(negedge clk);
      got_lat++;
    end
    check("rr_held_rsp",     32'(rsp_valid), 32'd1);
    check("rr_held_split",   32'(rsp_split), 32'd1);
    check("rr_held_latency", 32'(got_lat),   32'd4);
    $display("txn reset-in-D0 split store then held request completed lat=%0d", got_lat);

    // Random traffic against the byte-level model
    for (int t = 0; t < 300; t++) begin
      r_we    = 1'($urandom % 2);
      r_size  = 2'($urandom % 4);
      r_uns   = 1'($urandom % 2);
      r_addr  = ($urandom % 2) ? 10'($urandom_range(0, 63)) : 10'($urandom_range(1008, 1023));
      r_wdata = $urandom;
      n   = nbytes(r_size);
      off = r_addr[1:0];
      e_split = (int'(off) + n) > 4;
      e_a0_mask = 4'b0; e_d0_mask = 4'b0; e_a0_data = 32'b0; e_d0_data = 32'b0;
      for (int k = 0; k < 8; k++) begin
        if (k >= int'(off) && k < int'(off) + n) begin
          if (k < 4) e_a0_mask[k] = 1'b1;
          else       e_d0_mask[k-4] = 1'b1;
        end
        if (k >= int'(off) && k - int'(off) < 4) begin
          if (k < 4) e_a0_data[8*k +: 8]     = r_wdata[8*(k-int'(off)) +: 8];
          else       e_d0_data[8*(k-4) +: 8] = r_wdata[8*(k-int'(off)) +: 8];
        end
      end
      e_rdata = r_we ? 32'b0 : ref_load(r_addr, r_size, r_uns);
      run_req(r_we, r_size, r_uns, r_addr, r_wdata);
      if (r_we) ref_store(r_addr, r_size, r_wdata);
      check("rnd_rsp_seen", 32'(got_rsp),   32'd1);
      check("rnd_rdata",    got_rdata,      e_rdata);
      check("rnd_split",    32'(got_split), 32'(e_split));
      check("rnd_latency",  32'(got_lat),   e_split ? 32'd4 : 32'd3);
      check("rnd_pulse",    32'(got_after), 32'd0);
      check("rnd_a0_addr",  32'(a0_addr),   32'(r_addr[9:2]));
      check("rnd_a0_mask",  32'(a0_mask),   32'(e_a0_mask));
      check("rnd_a0_we",    32'(a0_we),     32'(r_we));
      check("rnd_d0_we",    32'(d0_we),     32'(r_we & e_split));
      if (r_we) check("rnd_a0_data", a0_data, e_a0_data);
      if (e_split) begin
        check("rnd_d0_addr", 32'(d0_addr), 32'(8'(r_addr[9:2] + 8'd1)));
        check("rnd_d0_mask", 32'(d0_mask), 32'(e_d0_mask));
        if (r_we) check("rnd_d0_data", d0_data, e_d0_data);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
